// File: rtl/decode_queue_if.sv
// Handshake/bus bundle for decode_queue: fetch-side push port, issue-side head port and occupancy.
// DECODE_ILLEGAL_EN adds the out_illegal / illegal_seen signals.
interface decode_queue_if #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_insn;
    logic [PC_WIDTH-1:0]   in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [12:0]           out_ctrl;
    logic [4:0]            out_rd;
    logic [4:0]            out_rs;
    logic [4:0]            out_rt;
    logic [4:0]            out_shamt;
    logic [4:0]            out_alu_op;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [26:0]           out_target;
    logic [CNT_W-1:0]      count;
`ifdef DECODE_ILLEGAL_EN
    logic                  out_illegal;
    logic                  illegal_seen;

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_ctrl, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_target, count, out_illegal, illegal_seen
    );
    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_ctrl, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_target, count, out_illegal, illegal_seen
    );
`else
    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_ctrl, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_target, count
    );
    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_ctrl, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_target, count
    );
`endif
endinterface

// File: rtl/decode_queue.sv
// Decode stage: classifies 32-bit instructions and buffers decoded bundles in a DEPTH-entry FIFO.
// Optional DECODE_ILLEGAL_EN build flags unlisted opcodes / alu_op>7 and keeps a sticky seen bit.
module decode_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    decode_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [12:0] decode_ctrl(input logic [31:0] insn);
        logic [4:0]  opc;
        logic [4:0]  aop;
        logic [12:0] c;
        opc = insn[31:27];
        aop = insn[6:2];
        c   = 13'd0;
        case (opc)
            5'd0: begin
                c[0] = 1'b1;
                c[2] = (aop == 5'd6);
                c[3] = (aop == 5'd7);
            end
            5'd1:    c[6]  = 1'b1;
            5'd2:    c[7]  = 1'b1;
            5'd3:    c[8]  = 1'b1;
            5'd4:    c[9]  = 1'b1;
            5'd5:    c[1]  = 1'b1;
            5'd6:    c[10] = 1'b1;
            5'd7:    c[4]  = 1'b1;
            5'd8:    c[5]  = 1'b1;
            5'd21:   c[12] = 1'b1;
            5'd22:   c[11] = 1'b1;
            default: c     = 13'd0;
        endcase
        return c;
    endfunction

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_s, empty_s, push_s, pop_s;
    logic [12:0]         ctrl_mem_q [DEPTH];
    logic [26:0]         fld_mem_q  [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [26:0]         head_fld_s;

    assign full_s     = (count_q == FULL_CNT);
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    assign push_s     = q.in_valid & ~full_s;
    assign pop_s      = q.out_ready & ~empty_s;
    assign head_fld_s = fld_mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; reset and flush both empty the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (reset || flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Entry storage; contents need no reset because head outputs are qualified by occupancy.
    always_ff @(posedge clock) begin
        if (push_s && !reset && !flush) begin
            ctrl_mem_q[wr_ptr_q] <= decode_ctrl(q.in_insn);
            fld_mem_q[wr_ptr_q]  <= q.in_insn[26:0];
            pc_mem_q[wr_ptr_q]   <= q.in_pc;
        end
    end

    // Head outputs, forced to zero while the queue is empty.
    always_comb begin
        q.in_ready  = ~full_s;
        q.out_valid = ~empty_s;
        q.count     = count_q;
        if (empty_s) begin
            q.out_pc     = {PC_WIDTH{1'b0}};
            q.out_ctrl   = 13'd0;
            q.out_rd     = 5'd0;
            q.out_rs     = 5'd0;
            q.out_rt     = 5'd0;
            q.out_shamt  = 5'd0;
            q.out_alu_op = 5'd0;
            q.out_imm    = {DATA_WIDTH{1'b0}};
            q.out_target = 27'd0;
        end else begin
            q.out_pc     = pc_mem_q[rd_ptr_q];
            q.out_ctrl   = ctrl_mem_q[rd_ptr_q];
            q.out_rd     = head_fld_s[26:22];
            q.out_rs     = head_fld_s[21:17];
            q.out_rt     = head_fld_s[16:12];
            q.out_shamt  = head_fld_s[11:7];
            q.out_alu_op = head_fld_s[6:2];
            q.out_imm    = DATA_WIDTH'($signed(head_fld_s[16:0]));
            q.out_target = head_fld_s;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    function automatic logic decode_illegal(input logic [31:0] insn);
        logic [4:0] opc;
        logic       ill;
        opc = insn[31:27];
        case (opc)
            5'd0:                                     ill = (insn[6:2] > 5'd7);
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
            5'd8, 5'd21, 5'd22:                       ill = 1'b0;
            default:                                  ill = 1'b1;
        endcase
        return ill;
    endfunction

    logic ill_mem_q [DEPTH];
    logic illegal_seen_q;

    // Illegal flag travels with its entry.
    always_ff @(posedge clock) begin
        if (push_s && !reset && !flush) begin
            ill_mem_q[wr_ptr_q] <= decode_illegal(q.in_insn);
        end
    end

    // Sticky record of any illegal entry consumed; flush leaves it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_seen_q <= 1'b0;
        end else if (pop_s && ill_mem_q[rd_ptr_q]) begin
            illegal_seen_q <= 1'b1;
        end else begin
            illegal_seen_q <= illegal_seen_q;
        end
    end

    // Optional status outputs.
    always_comb begin
        q.illegal_seen = illegal_seen_q;
        if (empty_s) begin
            q.out_illegal = 1'b0;
        end else begin
            q.out_illegal = ill_mem_q[rd_ptr_q];
        end
    end
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Randomised bench for decode_queue against a queue-based reference model, plus pinned literal checks.
module tb_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t mq[$];
    bit   seen_m  = 1'b0;
    bit   started = 1'b0;
    int   ops_tbl[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};

    decode_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(32), .PC_WIDTH(32)) dq ();

    decode_queue #(.DEPTH(DEPTH), .DATA_WIDTH(32), .PC_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .q     (dq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int class_bit(input logic [31:0] insn);
        case (int'(insn[31:27]))
            0:       return 0;
            1:       return 6;
            2:       return 7;
            3:       return 8;
            4:       return 9;
            5:       return 1;
            6:       return 10;
            7:       return 4;
            8:       return 5;
            21:      return 12;
            22:      return 11;
            default: return -1;
        endcase
    endfunction

    function automatic logic [12:0] m_ctrl(input logic [31:0] insn);
        logic [12:0] c;
        int b;
        b = class_bit(insn);
        c = (b < 0) ? 13'd0 : (13'd1 << b);
        if (b == 0 && insn[6:2] == 5'd6) c = c | 13'h004;
        if (b == 0 && insn[6:2] == 5'd7) c = c | 13'h008;
        return c;
    endfunction

    function automatic bit m_illegal(input logic [31:0] insn);
        int b;
        b = class_bit(insn);
        return (b < 0) || (b == 0 && insn[6:2] > 5'd7);
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [4:0]  op;
        int k;
        r = $urandom();
        k = $urandom_range(0, 13);
        if (k <= 10) op = 5'(ops_tbl[k]);
        else if (k == 11) op = 5'd0;
        else op = r[31:27];
        if (op == 5'd0) r[6:2] = 5'($urandom_range(0, 9));
        return {op, r[26:0]};
    endfunction

    // Compare DUT against the model, then advance the model with the inputs the DUT samples next edge.
    always @(negedge clock) begin
        ent_t h;
        bit   do_pop, do_push;
        ent_t nw;
        if (started) begin
            chk("count", 64'(dq.count), 64'(mq.size()));
            chk("in_ready", 64'(dq.in_ready), 64'(mq.size() < DEPTH));
            chk("out_valid", 64'(dq.out_valid), 64'(mq.size() != 0));
            h = (mq.size() != 0) ? mq[0] : '0;
            chk("out_pc", 64'(dq.out_pc), 64'(h.pc));
            chk("out_ctrl", 64'(dq.out_ctrl), (mq.size() != 0) ? 64'(m_ctrl(h.insn)) : 64'd0);
            chk("out_rd", 64'(dq.out_rd), 64'(h.insn[26:22]));
            chk("out_rs", 64'(dq.out_rs), 64'(h.insn[21:17]));
            chk("out_rt", 64'(dq.out_rt), 64'(h.insn[16:12]));
            chk("out_shamt", 64'(dq.out_shamt), 64'(h.insn[11:7]));
            chk("out_alu_op", 64'(dq.out_alu_op), 64'(h.insn[6:2]));
            chk("out_imm", 64'(dq.out_imm), 64'({{15{h.insn[16]}}, h.insn[16:0]}));
            chk("out_target", 64'(dq.out_target), 64'(h.insn[26:0]));
`ifdef DECODE_ILLEGAL_EN
            chk("out_illegal", 64'(dq.out_illegal), (mq.size() != 0) ? 64'(m_illegal(h.insn)) : 64'd0);
            chk("illegal_seen", 64'(dq.illegal_seen), 64'(seen_m));
`endif
        end
        if (reset) begin
            mq.delete();
            seen_m  = 1'b0;
            started = 1'b1;
        end else if (started) begin
            do_pop  = (mq.size() != 0) && dq.out_ready;
            do_push = dq.in_valid && (mq.size() < DEPTH);
            nw.pc   = dq.in_pc;
            nw.insn = dq.in_insn;
            if (do_pop && m_illegal(mq[0].insn)) seen_m = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(nw);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc, input logic rdy);
        dq.in_valid  = v;
        dq.in_insn   = insn;
        dq.in_pc     = pc;
        dq.out_ready = rdy;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) tick();
        chk("rst_count", 64'(dq.count), 64'd0);
        chk("rst_out_valid", 64'(dq.out_valid), 64'd0);
        chk("rst_in_ready", 64'(dq.in_ready), 64'd1);
        chk("rst_ctrl", 64'(dq.out_ctrl), 64'd0);
        reset = 1'b0;

        // addi r3,r1,-1
        drive(1'b1, 32'h28C3FFFF, 32'h10, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t1_valid", 64'(dq.out_valid), 64'd1);
        chk("t1_ctrl", 64'(dq.out_ctrl), 64'h002);
        chk("t1_rd", 64'(dq.out_rd), 64'd3);
        chk("t1_rs", 64'(dq.out_rs), 64'd1);
        chk("t1_imm", 64'(dq.out_imm), 64'hFFFFFFFF);
        chk("t1_pc", 64'(dq.out_pc), 64'h10);

        // fill past full with consumer stalled
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h28000000 | 32'(i), 32'h100 + 32'(4 * i), 1'b0);
            tick();
            if (i == 3) chk("t2_in_ready_full", 64'(dq.in_ready), 64'd0);
        end
        chk("t2_count_full", 64'(dq.count), 64'd4);
        drive(1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_order", 64'(dq.out_pc), 64'h100 + 64'(4 * i));
            tick();
        end
        chk("t2_drained", 64'(dq.out_valid), 64'd0);

        // steady push+pop at count=2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h08000000, 32'h200 + 32'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10000000 | 32'(i), 32'h300 + 32'(i), 1'b1);
            tick();
            chk("t3_count_steady", 64'(dq.count), 64'd2);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1);
        repeat (2) tick();

        // class decode corner cases
        drive(1'b1, 32'h00000018, 32'h400, 1'b0); tick();
        drive(1'b1, 32'hB0000000, 32'h404, 1'b0); tick();
        drive(1'b1, 32'h48000000, 32'h408, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t4_mul", 64'(dq.out_ctrl), 64'h005);
        dq.out_ready = 1'b1;
        tick();
        chk("t4_bex", 64'(dq.out_ctrl), 64'h800);
        tick();
        chk("t4_bubble", 64'(dq.out_ctrl), 64'h000);
        chk("t4_bubble_valid", 64'(dq.out_valid), 64'd1);
        tick();

        // flush with a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20000000, 32'h500 + 32'(i), 1'b0);
            tick();
        end
        chk("t5_count3", 64'(dq.count), 64'd3);
        drive(1'b1, 32'h38000000, 32'hDEAD0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t5_count0", 64'(dq.count), 64'd0);
        chk("t5_valid0", 64'(dq.out_valid), 64'd0);
        drive(1'b1, 32'h30000000, 32'h5A0, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t5_next_pc", 64'(dq.out_pc), 64'h5A0);
        tick();

`ifdef DECODE_ILLEGAL_EN
        drive(1'b1, 32'h48000000, 32'h600, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t6_out_illegal", 64'(dq.out_illegal), 64'd1);
        chk("t6_seen_before", 64'(dq.illegal_seen), 64'd0);
        dq.out_ready = 1'b1; tick(); dq.out_ready = 1'b0;
        chk("t6_seen_after", 64'(dq.illegal_seen), 64'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_seen_flush", 64'(dq.illegal_seen), 64'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_seen_reset", 64'(dq.illegal_seen), 64'd0);
`endif

        // randomised phases with varying pressure
        for (int ph = 0; ph < 15; ph++) begin
            int pv, pr;
            pv = $urandom_range(10, 100);
            pr = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(1, 100) <= pv, rand_insn(), $urandom(), $urandom_range(1, 100) <= pr);
                flush = ($urandom_range(0, 99) < 2);
                reset = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        flush = 1'b0;
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
